// File: rtl/sparrow_mem_arbiter.sv
// Two-port (fetch/data) arbiter onto one memory bus with an in-order response-ID queue.
// Define SPARROW_ARB_RR_EN to replace data priority + starvation counter with round-robin.
module sparrow_mem_arbiter #(
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter int unsigned STARVE_LIMIT    = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req_i,
   input  logic [31:0] if_addr_i,
   output logic        if_gnt_o,
   output logic        if_rvalid_o,
   output logic [31:0] if_rd_data_o,
   input  logic        d_req_i,
   input  logic [31:0] d_addr_i,
   input  logic        d_wr_i,
   input  logic [1:0]  d_byte_en_i,
   input  logic [31:0] d_wr_data_i,
   output logic        d_gnt_o,
   output logic        d_rvalid_o,
   output logic [31:0] d_rd_data_o,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   output logic        mem_wr_o,
   output logic [1:0]  mem_byte_en_o,
   output logic [31:0] mem_wr_data_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rd_data_i,
   output logic        arb_err_o
);

   localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam logic [PtrW-1:0] LastPtr = PtrW'(MAX_OUTSTANDING - 1);
   localparam logic [2:0] MaxCnt = 3'(MAX_OUTSTANDING);

   // Queue entry: port ID (0 = fetch, 1 = data) plus write flag for the data port.
   logic [MAX_OUTSTANDING-1:0] id_q;
   logic [MAX_OUTSTANDING-1:0] wr_q;
   logic [PtrW-1:0]            wptr_q;
   logic [PtrW-1:0]            rptr_q;
   logic [2:0]                 cnt_q;
   logic [2:0]                 cnt_after_pop;
   logic                       arb_err_q;

   logic q_empty;
   logic q_full;
   logic pop;
   logic pick_d;
   logic sel_d;
   logic sel_if;
   logic fire;
   logic head_id;
   logic head_wr;

`ifdef SPARROW_ARB_RR_EN
   logic rr_q;  // 1: data has priority on contention
`else
   localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);
   logic [3:0] starve_q;
`endif

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == LastPtr) ? '0 : p + 1'b1;
   endfunction

   // Full is evaluated after this cycle's pop so a response can free a slot for a new grant.
   always_comb begin
      q_empty       = (cnt_q == 3'd0);
      pop           = mem_rvalid_i & ~q_empty & ~reset;
      cnt_after_pop = cnt_q - {2'b00, pop};
      q_full        = (cnt_after_pop == MaxCnt);
`ifdef SPARROW_ARB_RR_EN
      pick_d        = d_req_i & (~if_req_i | rr_q);
`else
      pick_d        = d_req_i & ~(if_req_i & (starve_q == StarveMax));
`endif
      sel_d         = ~q_full & ~reset & pick_d;
      sel_if        = ~q_full & ~reset & if_req_i & ~pick_d;
      mem_req_o     = sel_d | sel_if;
      fire          = mem_req_o & mem_gnt_i;
      if_gnt_o      = fire & sel_if;
      d_gnt_o       = fire & sel_d;
      mem_addr_o    = sel_d ? d_addr_i : (sel_if ? if_addr_i : 32'd0);
      mem_wr_o      = sel_d & d_wr_i;
      mem_byte_en_o = sel_d ? d_byte_en_i : 2'b00;
      mem_wr_data_o = sel_d ? d_wr_data_i : 32'd0;
   end

   always_comb begin
      head_id      = id_q[rptr_q];
      head_wr      = wr_q[rptr_q];
      if_rvalid_o  = pop & ~head_id;
      d_rvalid_o   = pop & head_id;
      if_rd_data_o = if_rvalid_o ? mem_rd_data_i : 32'd0;
      d_rd_data_o  = (d_rvalid_o & ~head_wr) ? mem_rd_data_i : 32'd0;
      arb_err_o    = arb_err_q & ~reset;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         id_q      <= '0;
         wr_q      <= '0;
         wptr_q    <= '0;
         rptr_q    <= '0;
         cnt_q     <= 3'd0;
         arb_err_q <= 1'b0;
`ifdef SPARROW_ARB_RR_EN
         rr_q      <= 1'b1;
`else
         starve_q  <= 4'd0;
`endif
      end else begin
         if (fire) begin
            id_q[wptr_q] <= sel_d;
            wr_q[wptr_q] <= sel_d & d_wr_i;
            wptr_q       <= ptr_inc(wptr_q);
         end
         if (pop) begin
            rptr_q <= ptr_inc(rptr_q);
         end
         cnt_q <= cnt_after_pop + {2'b00, fire};
         if (mem_rvalid_i && q_empty) begin
            arb_err_q <= 1'b1;
         end
`ifdef SPARROW_ARB_RR_EN
         if (fire) begin
            rr_q <= sel_if;
         end
`else
         if (!if_req_i || if_gnt_o) begin
            starve_q <= 4'd0;
         end else if (d_gnt_o && starve_q != StarveMax) begin
            starve_q <= starve_q + 4'd1;
         end
`endif
      end
   end

endmodule

// File: tb/tb_sparrow_mem_arbiter.sv
// Table-driven bench for sparrow_mem_arbiter with a response scoreboard and a small memory model.
// Expected contention order follows SPARROW_ARB_RR_EN when defined.
module tb_sparrow_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        if_req_i = 1'b0;
   logic [31:0] if_addr_i = 32'd0;
   logic        if_gnt_o, if_rvalid_o;
   logic [31:0] if_rd_data_o;
   logic        d_req_i = 1'b0;
   logic [31:0] d_addr_i = 32'd0;
   logic        d_wr_i = 1'b0;
   logic [1:0]  d_byte_en_i = 2'b00;
   logic [31:0] d_wr_data_i = 32'd0;
   logic        d_gnt_o, d_rvalid_o;
   logic [31:0] d_rd_data_o;
   logic        mem_req_o, mem_wr_o;
   logic [31:0] mem_addr_o, mem_wr_data_o;
   logic [1:0]  mem_byte_en_o;
   logic        mem_gnt_i = 1'b0;
   logic        mem_rvalid_i = 1'b0;
   logic [31:0] mem_rd_data_i = 32'd0;
   logic        arb_err_o;

   always #5 clk = ~clk;

   sparrow_mem_arbiter #(
      .MAX_OUTSTANDING (2),
      .STARVE_LIMIT    (3)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .if_req_i      (if_req_i),
      .if_addr_i     (if_addr_i),
      .if_gnt_o      (if_gnt_o),
      .if_rvalid_o   (if_rvalid_o),
      .if_rd_data_o  (if_rd_data_o),
      .d_req_i       (d_req_i),
      .d_addr_i      (d_addr_i),
      .d_wr_i        (d_wr_i),
      .d_byte_en_i   (d_byte_en_i),
      .d_wr_data_i   (d_wr_data_i),
      .d_gnt_o       (d_gnt_o),
      .d_rvalid_o    (d_rvalid_o),
      .d_rd_data_o   (d_rd_data_o),
      .mem_req_o     (mem_req_o),
      .mem_addr_o    (mem_addr_o),
      .mem_wr_o      (mem_wr_o),
      .mem_byte_en_o (mem_byte_en_o),
      .mem_wr_data_o (mem_wr_data_o),
      .mem_gnt_i     (mem_gnt_i),
      .mem_rvalid_i  (mem_rvalid_i),
      .mem_rd_data_i (mem_rd_data_i),
      .arb_err_o     (arb_err_o)
   );

   typedef struct {
      logic rst, if_req, d_req, d_wr, mem_gnt, mem_rv;
      logic e_req, e_if, e_d;
   } vec_t;

   typedef struct {
      logic        port;
      logic [31:0] data;
   } resp_t;

   vec_t        tbl[$];
   resp_t       exp_q[$];
   logic [32:0] pend_q[$];
   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   logic        err_m = 1'b0;
   logic [31:0] if_a = 32'h1000;
   logic [31:0] d_a = 32'h2000;
   logic [31:0] d_wd = 32'h55AA;
   logic [7:0]  cont_d;

   function automatic logic [31:0] mem_f(input logic [31:0] a);
      return a ^ 32'hDEADAEEF;  // 0x1000 reads back as 0xDEADBEEF
   endfunction

   function automatic vec_t mk(input logic rst, input logic ifr, input logic dr, input logic dw,
                               input logic mg, input logic rv, input logic er, input logic ei,
                               input logic ed);
      vec_t v;
      v.rst = rst; v.if_req = ifr; v.d_req = dr; v.d_wr = dw; v.mem_gnt = mg; v.mem_rv = rv;
      v.e_req = er; v.e_if = ei; v.e_d = ed;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   initial begin
`ifdef SPARROW_ARB_RR_EN
      cont_d = 8'b0101_0101;
`else
      cont_d = 8'b0111_0111;
`endif
      //          rst ifr dr dw mg rv  req if  d
      // reset with both ports requesting: everything quiet
      tbl.push_back(mk(1, 1, 1, 0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(1, 1, 1, 0, 1, 0, 0, 0, 0));
      // single fetch read, response two cycles later
      tbl.push_back(mk(0, 1, 0, 0, 1, 0, 1, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0));
      // data write then fetch read
      tbl.push_back(mk(0, 0, 1, 1, 1, 0, 1, 0, 1));
      tbl.push_back(mk(0, 1, 0, 0, 1, 1, 1, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0));
      // contention, responses every cycle
      for (int i = 0; i < 8; i++)
         tbl.push_back(mk(0, 1, 1, 0, 1, i > 0, 1, ~cont_d[i], cont_d[i]));
      tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0));
      // queue full: fetch held off until a response frees a slot in the same cycle
      tbl.push_back(mk(0, 0, 1, 0, 1, 0, 1, 0, 1));
      tbl.push_back(mk(0, 0, 1, 0, 1, 0, 1, 0, 1));
      tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 0, 0, 1, 1, 1, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0));
      // bus stall, two reads outstanding, reset, then late responses
      tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 0, 1, 0, 1, 0, 1, 0, 1));
      tbl.push_back(mk(0, 1, 0, 0, 1, 0, 1, 1, 0));
      tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));

      for (int i = 0; i < tbl.size(); i++) begin
         vec_t  v;
         resp_t e;
         string r;
         v = tbl[i];
         r = $sformatf("row%0d", i);
         @(posedge clk);
         #1;
         reset         = v.rst;
         if_req_i      = v.if_req;
         if_addr_i     = if_a;
         d_req_i       = v.d_req;
         d_addr_i      = d_a;
         d_wr_i        = v.d_wr;
         d_byte_en_i   = 2'b10;
         d_wr_data_i   = d_wd;
         mem_gnt_i     = v.mem_gnt;
         mem_rvalid_i  = v.mem_rv;
         mem_rd_data_i = (pend_q.size() > 0) ? mem_f(pend_q[0][31:0]) : 32'hBAD0_0000;
         @(negedge clk);

         chk({r, " mem_req"}, {31'd0, mem_req_o}, {31'd0, v.e_req});
         chk({r, " if_gnt"}, {31'd0, if_gnt_o}, {31'd0, v.e_if});
         chk({r, " d_gnt"}, {31'd0, d_gnt_o}, {31'd0, v.e_d});
         chk({r, " arb_err"}, {31'd0, arb_err_o}, {31'd0, err_m & ~v.rst});
         if (v.e_if) begin
            chk({r, " if addr"}, mem_addr_o, if_a);
            chk({r, " if wr"}, {31'd0, mem_wr_o}, 32'd0);
         end
         if (v.e_d) begin
            chk({r, " d addr"}, mem_addr_o, d_a);
            chk({r, " d wr"}, {31'd0, mem_wr_o}, {31'd0, v.d_wr});
            chk({r, " d be"}, {30'd0, mem_byte_en_o}, 32'd2);
            chk({r, " d wdata"}, mem_wr_data_o, d_wd);
         end
         if (v.rst || (!v.if_req && !v.d_req))
            chk({r, " idle addr"}, mem_addr_o | mem_wr_data_o, 32'd0);

         // response check against the scoreboard head
         if (v.mem_rv && !v.rst && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({r, " if_rvalid"}, {31'd0, if_rvalid_o}, {31'd0, ~e.port});
            chk({r, " d_rvalid"}, {31'd0, d_rvalid_o}, {31'd0, e.port});
            chk({r, " if_rdata"}, if_rd_data_o, e.port ? 32'd0 : e.data);
            chk({r, " d_rdata"}, d_rd_data_o, e.port ? e.data : 32'd0);
         end else begin
            if (v.mem_rv && !v.rst) err_m = 1'b1;
            chk({r, " no rvalid"}, {30'd0, if_rvalid_o, d_rvalid_o}, 32'd0);
            chk({r, " no rdata"}, if_rd_data_o | d_rd_data_o, 32'd0);
         end

         // memory model bookkeeping
         if (v.mem_rv && pend_q.size() > 0) void'(pend_q.pop_front());
         if (mem_req_o && mem_gnt_i) pend_q.push_back({mem_wr_o, mem_addr_o});
         if (v.rst) begin
            exp_q.delete();
            err_m = 1'b0;
         end
         if (v.e_if) begin
            exp_q.push_back('{port: 1'b0, data: mem_f(if_a)});
            if_a = if_a + 32'd4;
         end
         if (v.e_d) begin
            exp_q.push_back('{port: 1'b1, data: v.d_wr ? 32'd0 : mem_f(d_a)});
            d_a  = d_a + 32'd4;
            d_wd = d_wd + 32'h0101;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sparrow_mem_arbiter.md
# sparrow_mem_arbiter

Two-port arbiter that shares one unified memory bus between the Sparrow instruction-fetch port and the data (load/store) port. It sits between the core's fetch and data memory interfaces and a single-ported memory or interconnect. Requests are arbitrated per cycle under a request/grant handshake. Read responses are returned in order to the originating port through a small outstanding-transaction ID queue.

## Interface
- MAX_OUTSTANDING, 2: depth of the response-ID queue (1..4); grants stall when full.
- STARVE_LIMIT, 3: consecutive data grants allowed while fetch is waiting before fetch is forced through (1..15).
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req_i  in  1  fetch request; must hold stable with address until if_gnt_o.
- if_addr_i  in  32  fetch address.
- if_gnt_o  out  1  fetch request accepted this cycle.
- if_rvalid_o  out  1  fetch read data valid.
- if_rd_data_o  out  32  fetch read data.
- d_req_i  in  1  data request; must hold stable with payload until d_gnt_o.
- d_addr_i  in  32  data address.
- d_wr_i  in  1  1 = write, 0 = read.
- d_byte_en_i  in  2  access size code, passed through unchanged.
- d_wr_data_i  in  32  write data.
- d_gnt_o  out  1  data request accepted this cycle.
- d_rvalid_o  out  1  data response valid (reads and write acks).
- d_rd_data_o  out  32  data read data (0 on write acks).
- mem_req_o  out  1  bus request.
- mem_addr_o / mem_wr_o / mem_byte_en_o / mem_wr_data_o  out  32/1/2/32  muxed payload of the selected port.
- mem_gnt_i  in  1  bus accepted request.
- mem_rvalid_i  in  1  response valid; exactly one per accepted request, in order.
- mem_rd_data_i  in  32  response data.
- arb_err_o  out  1  sticky: response arrived with queue empty.

## Operation
- Selection is combinational from current requests and state:
  - Default priority is data over fetch.
  - If starve_cnt == STARVE_LIMIT and if_req_i is high, fetch wins.
- mem_req_o = (if_req_i | d_req_i) & !q_full. The payload is the selected port's payload. If no port is selected, the payload is 0.
- A transfer fires when mem_req_o & mem_gnt_i. Only the selected port's gnt is asserted. The port ID (0 = fetch, 1 = data) is pushed to the queue.
- starve_cnt (4 bits):
  - Increments on a data transfer while if_req_i is high, saturating at STARVE_LIMIT.
  - Clears on any fetch transfer, or when if_req_i is low.
- Response routing:
  - mem_rvalid_i pops the queue head.
  - Head = 0: drive if_rvalid_o and if_rd_data_o = mem_rd_data_i.
  - Head = 1: drive d_rvalid_o. d_rd_data_o = mem_rd_data_i for reads, 0 for writes. A write flag is stored with the ID.
  - Non-selected rd_data outputs are 0.
- Queue boundaries:
  - When full, no grant is issued.
  - A push and a pop in the same cycle leaves the count unchanged. This is allowed when full: the pop frees the slot for the push. Full is computed after the pop, combinationally.
  - Pointers wrap modulo MAX_OUTSTANDING.
- mem_rvalid_i with the queue empty: the response is dropped, no port rvalid is raised, and arb_err_o is set until reset.

## Timing
- Grant is zero-latency: gnt is asserted in the same cycle as an accepted request.
- Response latency equals memory latency; the arbiter adds 0 cycles. rvalid and data are combinational from mem_rvalid_i and the queue head.
- Back-to-back transfers: one per cycle while mem_gnt_i is high and the queue is not full.
- Reset (any cycle, including mid-transaction):
  - Queue is cleared, starve_cnt = 0, arb_err_o = 0, RR pointer = data.
  - All outputs are 0 during reset.
  - Responses for pre-reset requests arriving after reset are treated as empty-queue responses.

## Configuration
- SPARROW_ARB_RR_EN defined: fixed priority and starve_cnt are removed.
  - A 1-bit round-robin pointer selects between ports. On contention, the port not granted last wins.
  - The pointer updates only on a transfer. STARVE_LIMIT is ignored.
- Undefined: data-priority with the starvation counter, as described above.

## Test plan
- Single fetch read:
  - Stimulus: if_req_i = 1, addr 0x1000; mem_gnt_i = 1; rvalid 2 cycles later with 0xDEADBEEF.
  - Required: if_gnt_o in cycle 0; if_rvalid_o = 1 with if_rd_data_o = 0xDEADBEEF; d_rvalid_o stays 0.
- Contention, default build, STARVE_LIMIT = 3:
  - Stimulus: both ports request continuously; mem_gnt_i = 1; responses returned every cycle.
  - Required grant order: D, D, D, F, D, D, D, F.
- Contention with SPARROW_ARB_RR_EN:
  - Stimulus: same as above.
  - Required grant order: D, F, D, F.
- Queue full, MAX_OUTSTANDING = 2:
  - Stimulus: two data reads granted with no response; then a fetch request.
  - Required: mem_req_o = 0 and if_gnt_o = 0. When mem_rvalid_i arrives, the fetch is granted in the same cycle. Responses go D, D, then F, in order.
- Mixed write/read:
  - Stimulus: data write to 0x2000 with 0x55AA; then fetch read.
  - Required: d_rvalid_o with d_rd_data_o = 0; then if_rvalid_o with memory data.
- Reset mid-operation:
  - Stimulus: reset asserted with 2 reads outstanding; a late mem_rvalid_i arrives after reset.
  - Required: no port rvalid is raised; arb_err_o = 1.
